// File: rtl/dm_responder_if.sv
// Load/store request and response channel between the memory stage (master)
// and the data-memory responder (slave).
interface dm_responder_if;
   logic        req_valid;
   logic        req_ready;
   logic        req_we;
   logic [1:0]  req_size;
   logic        req_sext;
   logic [31:0] req_addr;
   logic [31:0] req_wdata;
   logic [31:0] req_pc;
   logic        resp_valid;
   logic        resp_ready;
   logic [31:0] resp_rdata;
   logic        resp_err;

   modport master (
      output req_valid, req_we, req_size, req_sext, req_addr, req_wdata, req_pc,
      output resp_ready,
      input  req_ready, resp_valid, resp_rdata, resp_err
   );

   modport slave (
      input  req_valid, req_we, req_size, req_sext, req_addr, req_wdata, req_pc,
      input  resp_ready,
      output req_ready, resp_valid, resp_rdata, resp_err
   );
endinterface

// File: rtl/dm_responder.sv
// Multi-cycle data-memory responder: one request at a time, WAIT_CYCLES wait states.
// Optional store trace is enabled with the DM_TRACE_EN macro.
module dm_responder #(
   parameter int DEPTH_WORDS = 3072,
   parameter int WAIT_CYCLES = 1
) (
   input  logic          clk,
   input  logic          reset,
   dm_responder_if.slave bus
);

   localparam int AW = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
   localparam logic [3:0] WAIT_INIT = (WAIT_CYCLES == 0) ? 4'd0 : 4'(WAIT_CYCLES - 1);

   typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

   state_t      state_reg, state_next;
   logic [3:0]  cnt_reg, cnt_next;
   logic        accept, enter_resp, retire, req_ready;

   logic        we_reg, sext_reg;
   logic [1:0]  size_reg;
   logic [31:0] addr_reg, wdata_reg, pc_reg;

   logic        resp_valid_reg, resp_err_reg;
   logic [31:0] resp_rdata_reg;

   // Effective request: live inputs when committing straight out of IDLE, latched otherwise.
   logic        eff_we, eff_sext;
   logic [1:0]  eff_size;
   logic [31:0] eff_addr, eff_wdata, eff_pc;

   logic [31:0]       word_idx;
   logic              req_err;
   logic [AW-1:0]     idx;
   logic [3:0]        lane_mask;
   logic [3:0][7:0]   wr_lanes;
   logic              wr_en;
   logic [31:0]       rd_word;
   logic [15:0]       rd_shift;
   logic [31:0]       load_ext;

   // ---------------- FSM ----------------
   always_ff @(posedge clk) begin
      if (reset) begin
         state_reg <= IDLE;
         cnt_reg   <= '0;
      end else begin
         state_reg <= state_next;
         cnt_reg   <= cnt_next;
      end
   end

   always_comb begin
      state_next = state_reg;
      cnt_next   = cnt_reg;
      accept     = 1'b0;
      enter_resp = 1'b0;
      retire     = 1'b0;
      req_ready  = 1'b0;
      case (state_reg)
         IDLE: begin
            req_ready = 1'b1;
            if (bus.req_valid) begin
               accept = 1'b1;
               if (WAIT_CYCLES == 0) begin
                  state_next = RESP;
                  enter_resp = 1'b1;
               end else begin
                  state_next = WAIT;
                  cnt_next   = WAIT_INIT;
               end
            end
         end
         WAIT: begin
            if (cnt_reg == 4'd0) begin
               state_next = RESP;
               enter_resp = 1'b1;
            end else begin
               cnt_next = cnt_reg - 4'd1;
            end
         end
         RESP: begin
            if (bus.resp_ready) begin
               retire     = 1'b1;
               state_next = IDLE;
            end
         end
         default: state_next = IDLE;
      endcase
   end

   // ---------------- request latch ----------------
   always_ff @(posedge clk) begin
      if (reset) begin
         we_reg    <= 1'b0;
         size_reg  <= 2'd0;
         sext_reg  <= 1'b0;
         addr_reg  <= '0;
         wdata_reg <= '0;
         pc_reg    <= '0;
      end else if (accept) begin
         we_reg    <= bus.req_we;
         size_reg  <= bus.req_size;
         sext_reg  <= bus.req_sext;
         addr_reg  <= bus.req_addr;
         wdata_reg <= bus.req_wdata;
         pc_reg    <= bus.req_pc;
      end
   end

   always_comb begin
      if (state_reg == IDLE) begin
         eff_we    = bus.req_we;
         eff_size  = bus.req_size;
         eff_sext  = bus.req_sext;
         eff_addr  = bus.req_addr;
         eff_wdata = bus.req_wdata;
         eff_pc    = bus.req_pc;
      end else begin
         eff_we    = we_reg;
         eff_size  = size_reg;
         eff_sext  = sext_reg;
         eff_addr  = addr_reg;
         eff_wdata = wdata_reg;
         eff_pc    = pc_reg;
      end
   end

   // ---------------- decode ----------------
   always_comb begin
      word_idx = {2'b00, eff_addr[31:2]};
      req_err  = (eff_size == 2'd3)
               | ((eff_size == 2'd1) & eff_addr[0])
               | ((eff_size == 2'd2) & (eff_addr[1:0] != 2'b00))
               | (word_idx >= 32'(DEPTH_WORDS));
      idx      = eff_addr[2 +: AW];
      wr_en    = enter_resp & eff_we & ~req_err;
   end

   // Store data is replicated across lanes so the mask alone selects placement.
   always_comb begin
      lane_mask = 4'b0000;
      wr_lanes  = eff_wdata;
      case (eff_size)
         2'd0: begin
            lane_mask = 4'b0001 << eff_addr[1:0];
            wr_lanes  = {4{eff_wdata[7:0]}};
         end
         2'd1: begin
            lane_mask = eff_addr[1] ? 4'b1100 : 4'b0011;
            wr_lanes  = {2{eff_wdata[15:0]}};
         end
         2'd2: lane_mask = 4'b1111;
         default: lane_mask = 4'b0000;
      endcase
   end

   // ---------------- storage, one byte-wide array per lane ----------------
   for (genvar gi = 0; gi < 4; gi++) begin : g_lane
      logic [7:0] lane_mem [DEPTH_WORDS];
      logic [7:0] rd_byte;

      always_ff @(posedge clk) begin
         if (reset) begin
            for (int w = 0; w < DEPTH_WORDS; w++) begin
               lane_mem[w] <= 8'h00;
            end
         end else if (wr_en && lane_mask[gi]) begin
            lane_mem[idx] <= wr_lanes[gi];
         end
      end

      assign rd_byte = lane_mem[idx];
   end

   assign rd_word = {g_lane[3].rd_byte, g_lane[2].rd_byte,
                     g_lane[1].rd_byte, g_lane[0].rd_byte};

   // ---------------- load extension ----------------
   always_comb begin
      rd_shift = 16'(rd_word >> {eff_addr[1:0], 3'b000});
      case (eff_size)
         2'd0: load_ext = eff_sext ? {{24{rd_shift[7]}}, rd_shift[7:0]}
                                   : {24'h000000, rd_shift[7:0]};
         2'd1: load_ext = eff_sext ? {{16{rd_shift[15]}}, rd_shift[15:0]}
                                   : {16'h0000, rd_shift[15:0]};
         default: load_ext = rd_word;
      endcase
   end

   // ---------------- response registers ----------------
   always_ff @(posedge clk) begin
      if (reset) begin
         resp_valid_reg <= 1'b0;
         resp_err_reg   <= 1'b0;
         resp_rdata_reg <= '0;
      end else if (enter_resp) begin
         resp_valid_reg <= 1'b1;
         resp_err_reg   <= req_err;
         resp_rdata_reg <= (!eff_we && !req_err) ? load_ext : 32'h0;
      end else if (retire) begin
         resp_valid_reg <= 1'b0;
         resp_err_reg   <= 1'b0;
         resp_rdata_reg <= '0;
      end
   end

   assign bus.req_ready  = req_ready;
   assign bus.resp_valid = resp_valid_reg;
   assign bus.resp_err   = resp_err_reg;
   assign bus.resp_rdata = resp_rdata_reg;

`ifdef DM_TRACE_EN
   logic [31:0] merged_word;

   always_comb begin
      merged_word = rd_word;
      for (int k = 0; k < 4; k++) begin
         if (lane_mask[k]) merged_word[8*k +: 8] = wr_lanes[k];
      end
   end

   always_ff @(posedge clk) begin
      if (!reset && wr_en) begin
         $display("@%h: *%h <= %h", eff_pc, {eff_addr[31:2], 2'b00}, merged_word);
      end
   end
`else
   logic unused_pc;
   assign unused_pc = ^eff_pc;
`endif

endmodule

// File: tb/tb_dm_responder.sv
// Directed self-checking bench for dm_responder (DEPTH_WORDS=3072, WAIT_CYCLES=1).
module tb_dm_responder;
   localparam int DEPTH = 3072;

   logic clk = 1'b0;
   logic reset;
   int   total = 0;
   int   bad   = 0;

   always #5 clk = ~clk;

   dm_responder_if bus();

   dm_responder #(.DEPTH_WORDS(DEPTH), .WAIT_CYCLES(1)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic drive(input logic we, input logic [1:0] size, input logic sext,
                        input logic [31:0] addr, input logic [31:0] wdata);
      bus.req_valid = 1'b1;
      bus.req_we    = we;
      bus.req_size  = size;
      bus.req_sext  = sext;
      bus.req_addr  = addr;
      bus.req_wdata = wdata;
      bus.req_pc    = 32'h0000_1000 + addr;
   endtask

   // One full transaction; request fields are scrambled after acceptance.
   task automatic txn(input string tag, input logic we, input logic [1:0] size,
                      input logic sext, input logic [31:0] addr, input logic [31:0] wdata,
                      input logic [31:0] exp_rdata, input logic exp_err);
      int n;
      logic [31:0] rdata;
      logic err;
      drive(we, size, sext, addr, wdata);
      step();
      bus.req_valid = 1'b0;
      bus.req_wdata = ~wdata;
      bus.req_addr  = addr ^ 32'h0000_0004;
      bus.req_sext  = ~sext;
      n = 0;
      while (bus.resp_valid !== 1'b1 && n < 20) begin
         step();
         n++;
      end
      if (bus.resp_valid !== 1'b1) begin
         check({tag, "_timeout"}, 32'(bus.resp_valid), 32'd1);
         rdata = 32'hxxxx_xxxx;
         err   = 1'bx;
      end else begin
         rdata = bus.resp_rdata;
         err   = bus.resp_err;
      end
      bus.resp_ready = 1'b1;
      step();
      bus.resp_ready = 1'b0;
      $display("txn %s we=%0d size=%0d sext=%0d addr=%h wdata=%h -> rdata=%h err=%0d",
               tag, we, size, sext, addr, wdata, rdata, err);
      check({tag, "_rdata"}, rdata, exp_rdata);
      check({tag, "_err"}, 32'(err), 32'(exp_err));
      check({tag, "_idle"}, {30'd0, bus.resp_valid, bus.req_ready}, 32'd1);
   endtask

   initial begin
      reset          = 1'b1;
      bus.req_valid  = 1'b0;
      bus.req_we     = 1'b0;
      bus.req_size   = 2'd0;
      bus.req_sext   = 1'b0;
      bus.req_addr   = '0;
      bus.req_wdata  = '0;
      bus.req_pc     = '0;
      bus.resp_ready = 1'b0;
      repeat (3) step();
      reset = 1'b0;

      check("rst_req_ready",  32'(bus.req_ready), 32'd1);
      check("rst_resp_valid", 32'(bus.resp_valid), 32'd0);
      check("rst_rdata",      bus.resp_rdata, 32'h0);
      check("rst_err",        32'(bus.resp_err), 32'd0);

      // Latency: accept edge -> WAIT, next edge -> RESP.
      drive(1'b0, 2'd2, 1'b0, 32'h0, 32'h0);
      step();
      bus.req_valid = 1'b0;
      check("lat_valid_wait", 32'(bus.resp_valid), 32'd0);
      check("lat_ready_wait", 32'(bus.req_ready), 32'd0);
      step();
      check("lat_valid_resp", 32'(bus.resp_valid), 32'd1);
      check("lat_rdata",      bus.resp_rdata, 32'h0);
      check("lat_err",        32'(bus.resp_err), 32'd0);
      bus.resp_ready = 1'b1;
      step();
      bus.resp_ready = 1'b0;
      check("lat_retire", {30'd0, bus.resp_valid, bus.req_ready}, 32'd1);
      $display("txn lat load word addr=00000000 done");

      // Lane merge.
      txn("st_w10",  1'b1, 2'd2, 1'b0, 32'h10, 32'h1234_5678, 32'h0, 1'b0);
      txn("st_b11",  1'b1, 2'd0, 1'b0, 32'h11, 32'hFFFF_FFAB, 32'h0, 1'b0);
      txn("ld_w10",  1'b0, 2'd2, 1'b0, 32'h10, 32'h0, 32'h1234_AB78, 1'b0);

      // Extension.
      txn("st_w10b", 1'b1, 2'd2, 1'b0, 32'h10, 32'h8001_7FFF, 32'h0, 1'b0);
      txn("ld_h12s", 1'b0, 2'd1, 1'b1, 32'h12, 32'h0, 32'hFFFF_8001, 1'b0);
      txn("ld_h12z", 1'b0, 2'd1, 1'b0, 32'h12, 32'h0, 32'h0000_8001, 1'b0);
      txn("ld_b10s", 1'b0, 2'd0, 1'b1, 32'h10, 32'h0, 32'hFFFF_FFFF, 1'b0);
      txn("ld_b11s", 1'b0, 2'd0, 1'b1, 32'h11, 32'h0, 32'h0000_007F, 1'b0);
      txn("ld_b13z", 1'b0, 2'd0, 1'b0, 32'h13, 32'h0, 32'h0000_0080, 1'b0);
      txn("ld_h10s", 1'b0, 2'd1, 1'b1, 32'h10, 32'h0, 32'h0000_7FFF, 1'b0);

      // Errors leave memory untouched.
      txn("st_w04",   1'b1, 2'd2, 1'b0, 32'h4, 32'h0BAD_F00D, 32'h0, 1'b0);
      txn("err_st6",  1'b1, 2'd2, 1'b0, 32'h6, 32'h1111_1111, 32'h0, 1'b1);
      txn("err_h3",   1'b0, 2'd1, 1'b1, 32'h3, 32'h0, 32'h0, 1'b1);
      txn("err_sz3",  1'b0, 2'd3, 1'b0, 32'h4, 32'h0, 32'h0, 1'b1);
      txn("err_oor",  1'b0, 2'd2, 1'b0, DEPTH * 4, 32'h0, 32'h0, 1'b1);
      txn("err_oors", 1'b1, 2'd2, 1'b0, DEPTH * 4, 32'h2222_2222, 32'h0, 1'b1);
      txn("ld_w04",   1'b0, 2'd2, 1'b0, 32'h4, 32'h0, 32'h0BAD_F00D, 1'b0);
      txn("st_h06",   1'b1, 2'd1, 1'b0, 32'h6, 32'hFFFF_1234, 32'h0, 1'b0);
      txn("ld_w04b",  1'b0, 2'd2, 1'b0, 32'h4, 32'h0, 32'h1234_F00D, 1'b0);
      txn("st_last",  1'b1, 2'd2, 1'b0, DEPTH * 4 - 4, 32'hCAFE_BABE, 32'h0, 1'b0);
      txn("ld_last",  1'b0, 2'd2, 1'b0, DEPTH * 4 - 4, 32'h0, 32'hCAFE_BABE, 1'b0);

      // Backpressure: response held while a new request is presented.
      drive(1'b0, 2'd2, 1'b0, 32'h10, 32'h0);
      step();
      bus.req_valid = 1'b0;
      step();
      check("bp_valid0", 32'(bus.resp_valid), 32'd1);
      drive(1'b1, 2'd2, 1'b0, 32'h10, 32'h5555_5555);
      for (int i = 0; i < 5; i++) begin
         step();
         check("bp_valid", 32'(bus.resp_valid), 32'd1);
         check("bp_rdata", bus.resp_rdata, 32'h8001_7FFF);
         check("bp_err",   32'(bus.resp_err), 32'd0);
         check("bp_ready", 32'(bus.req_ready), 32'd0);
      end
      bus.req_valid  = 1'b0;
      bus.resp_ready = 1'b1;
      step();
      bus.resp_ready = 1'b0;
      check("bp_retire", {30'd0, bus.resp_valid, bus.req_ready}, 32'd1);
      $display("txn backpressure load addr=00000010 held 5 cycles");
      txn("bp_noacc", 1'b0, 2'd2, 1'b0, 32'h10, 32'h0, 32'h8001_7FFF, 1'b0);

      // Reset during WAIT of a store.
      drive(1'b1, 2'd2, 1'b0, 32'h20, 32'hDEAD_BEEF);
      step();
      bus.req_valid = 1'b0;
      reset = 1'b1;
      step();
      reset = 1'b0;
      check("rw_req_ready",  32'(bus.req_ready), 32'd1);
      check("rw_resp_valid", 32'(bus.resp_valid), 32'd0);
      check("rw_rdata",      bus.resp_rdata, 32'h0);
      check("rw_err",        32'(bus.resp_err), 32'd0);
      $display("txn reset during store wait addr=00000020");
      txn("rw_ld20", 1'b0, 2'd2, 1'b0, 32'h20, 32'h0, 32'h0, 1'b0);
      txn("rw_ld10", 1'b0, 2'd2, 1'b0, 32'h10, 32'h0, 32'h0, 1'b0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
